// File: rtl/step_pulse_shaper.sv
// STEP/DIR shaper: turns divider rate ticks into driver-legal pulses with
// DIR setup, minimum high/low widths, target stopping and a position count.
module step_pulse_shaper #(
    parameter int POS_BITS         = 32,
    parameter int PULSE_CYCLES     = 50,
    parameter int DIR_SETUP_CYCLES = 20,
    parameter int CNT_BITS         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                step_req,
    input  logic [POS_BITS-1:0] target_pos,
    input  logic                pos_load,
    input  logic [POS_BITS-1:0] pos_load_value,
    input  logic                overrun_clr,
    output logic                step,
    output logic                dir,
    output logic [POS_BITS-1:0] position,
    output logic                busy,
    output logic                at_target,
    output logic                overrun
);

    typedef enum logic [1:0] {
        IDLE,
        DIR_SETUP,
        PULSE_HIGH,
        PULSE_LOW
    } state_t;

    localparam logic [CNT_BITS-1:0] PULSE_LAST = CNT_BITS'(PULSE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] SETUP_LAST = CNT_BITS'(DIR_SETUP_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);
    localparam logic [POS_BITS-1:0] POS_ONE    = POS_BITS'(1);

    state_t                state, state_n;
    logic [CNT_BITS-1:0]   cnt, cnt_n;
    logic                  step_n, dir_n;
    logic [POS_BITS-1:0]   pos_n;
    logic                  pending, pending_n;
    logic                  overrun_n;
    logic                  step_req_d;
    logic                  tick;
    logic                  want;
    logic                  clr_pend;

    assign tick      = step_req & ~step_req_d;
    assign want      = $signed(target_pos) > $signed(position);
    assign busy      = (state != IDLE);
    assign at_target = (position == target_pos);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
            position   <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            step_req_d <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            step       <= step_n;
            dir        <= dir_n;
            position   <= pos_n;
            pending    <= pending_n;
            overrun    <= overrun_n;
            step_req_d <= step_req;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        step_n    = step;
        dir_n     = dir;
        pos_n     = position;
        clr_pend  = 1'b0;
        pending_n = pending;
        overrun_n = overrun;

        unique case (state)
            IDLE: begin
                // a load wins over starting a pulse; the request stays queued
                if (pos_load) begin
                    pos_n = pos_load_value;
                end else if (pending && enable) begin
                    if (position == target_pos) begin
                        clr_pend = 1'b1;
                    end else if (want != dir) begin
                        dir_n   = want;
                        cnt_n   = SETUP_LAST;
                        state_n = DIR_SETUP;
                    end else begin
                        step_n   = 1'b1;
                        clr_pend = 1'b1;
                        cnt_n    = PULSE_LAST;
                        state_n  = PULSE_HIGH;
                    end
                end
            end
            DIR_SETUP: begin
                if (cnt == '0) begin
                    step_n   = 1'b1;
                    clr_pend = 1'b1;
                    cnt_n    = PULSE_LAST;
                    state_n  = PULSE_HIGH;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            PULSE_HIGH: begin
                if (cnt == '0) begin
                    step_n  = 1'b0;
                    pos_n   = dir ? position + POS_ONE : position - POS_ONE;
                    cnt_n   = PULSE_LAST;
                    state_n = PULSE_LOW;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            PULSE_LOW: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (clr_pend) pending_n = 1'b0;
        if (tick && !pending) pending_n = 1'b1;
        if (!enable) pending_n = 1'b0;

        if (overrun_clr) overrun_n = 1'b0;
        if (tick && pending) overrun_n = 1'b1;
    end

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Bench for step_pulse_shaper: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_step_pulse_shaper;

    localparam int PB = 8;
    localparam int PC = 4;
    localparam int DS = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          step_req = 1'b0;
    logic [PB-1:0] target_pos = '0;
    logic          pos_load = 1'b0;
    logic [PB-1:0] pos_load_value = '0;
    logic          overrun_clr = 1'b0;
    logic          step, dir, busy, at_target, overrun;
    logic [PB-1:0] position;

    int checks = 0;
    int errors = 0;

    // model: pulse phases are edge timestamps, not a state machine
    longint e = 0;
    longint rise_at = -1000;
    longint fall_at = -1000;
    longint free_at = 0;
    logic signed [PB-1:0] m_pos = '0;
    logic m_dir = 1'b0;
    logic m_ovr = 1'b0;
    logic m_pend = 1'b0;
    logic m_reqd = 1'b0;

    step_pulse_shaper #(
        .POS_BITS(PB),
        .PULSE_CYCLES(PC),
        .DIR_SETUP_CYCLES(DS),
        .CNT_BITS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .step_req(step_req),
        .target_pos(target_pos),
        .pos_load(pos_load),
        .pos_load_value(pos_load_value),
        .overrun_clr(overrun_clr),
        .step(step),
        .dir(dir),
        .position(position),
        .busy(busy),
        .at_target(at_target),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic tick, want, clr, np;
        e++;
        if (!rst_n) begin
            m_pos = '0; m_dir = 1'b0; m_ovr = 1'b0;
            m_pend = 1'b0; m_reqd = 1'b0;
            rise_at = -1000; fall_at = -1000; free_at = e;
            return;
        end
        tick = step_req & ~m_reqd;
        clr = 1'b0;
        if (e > free_at) begin
            if (pos_load) begin
                m_pos = pos_load_value;
            end else if (m_pend && enable) begin
                if (m_pos == $signed(target_pos)) begin
                    clr = 1'b1;
                end else begin
                    want = $signed(target_pos) > m_pos;
                    rise_at = (want != m_dir) ? e + DS : e;
                    m_dir = want;
                    fall_at = rise_at + PC;
                    free_at = fall_at + PC;
                end
            end
        end
        if (e == rise_at) clr = 1'b1;
        if (e == fall_at) m_pos = m_dir ? m_pos + 8'sd1 : m_pos - 8'sd1;
        if (tick && m_pend) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
        np = (tick && !m_pend) ? 1'b1 : (clr ? 1'b0 : m_pend);
        if (!enable) np = 1'b0;
        m_pend = np;
        m_reqd = step_req;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("step", {31'd0, step}, {31'd0, (e >= rise_at && e < fall_at)});
        chk("dir", {31'd0, dir}, {31'd0, m_dir});
        chk("position", {24'd0, position}, {24'd0, $unsigned(m_pos)});
        chk("busy", {31'd0, busy}, {31'd0, (e < free_at)});
        chk("at_target", {31'd0, at_target},
            {31'd0, (m_pos == $signed(target_pos))});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    task automatic tick_pulse(input int gap);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        repeat (gap - 1) cyc();
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    initial begin
        bit hit;

        // 1: reset with a toggling request, then quiet release
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_req = 1'($urandom_range(0, 1));
            cyc();
        end
        step_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("rst_pos", {24'd0, position}, 32'd0);

        // 2: forward move to 3, extra tick discarded
        enable = 1'b1;
        target_pos = 8'd3;
        repeat (4) tick_pulse(12);
        chk("fwd_pos", {24'd0, position}, 32'd3);
        chk("fwd_at", {31'd0, at_target}, 32'd1);

        // 3: reversal to -2
        target_pos = 8'hFE;
        repeat (6) tick_pulse(12);
        chk("rev_pos", {24'd0, position}, 32'hFE);

        // 4: ticks faster than the pulse rate
        target_pos = 8'd100;
        repeat (10) tick_pulse(3);
        repeat (30) cyc();
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("ovr_clr", {31'd0, overrun}, 32'd0);

        // 5: reset during the second high cycle
        tick_pulse(1);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (e == rise_at + 1) hit = 1'b1;
            else cyc();
        end
        if (!hit) bound_fail("mid_pulse_wait");
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_pos", {24'd0, position}, 32'd0);
        chk("midrst_step", {31'd0, step}, 32'd0);
        repeat (3) cyc();

        // 6: load, wrap-direction step, ignored load, disabled ticks
        pos_load_value = 8'h7F;
        pos_load = 1'b1;
        cyc();
        pos_load = 1'b0;
        pos_load_value = 8'($urandom);
        chk("load_pos", {24'd0, position}, 32'h7F);
        target_pos = 8'h80;
        tick_pulse(12);
        chk("wrap_pos", {24'd0, position}, 32'h7E);
        target_pos = 8'h00;
        tick_pulse(1);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (e >= fall_at && e + 1 < free_at) hit = 1'b1;
            else cyc();
        end
        if (!hit) bound_fail("low_phase_wait");
        pos_load_value = 8'h11;
        pos_load = 1'b1;
        cyc();
        pos_load = 1'b0;
        repeat (8) cyc();
        chk("ign_load", {24'd0, position}, 32'h7D);
        enable = 1'b0;
        repeat (4) tick_pulse(3);
        chk("dis_pos", {24'd0, position}, 32'h7D);
        chk("dis_ovr", {31'd0, overrun}, 32'd0);

        // random traffic
        enable = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) step_req = ~step_req;
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) target_pos = 8'($urandom);
            pos_load = ($urandom_range(0, 24) == 0);
            pos_load_value = 8'($urandom);
            overrun_clr = ($urandom_range(0, 14) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
